// File: rtl/oq_regs_eval_status_if.sv
// Bus bundle for the output-queue status evaluator: src/dst update feeds,
// config/initialise path and per-queue status outputs toward the arbiter.
interface oq_regs_eval_status_if #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
    parameter int PKTS_IN_RAM_WIDTH = 16,
    parameter int WORDS_WIDTH       = 19,
    parameter int ITER_WIDTH        = 32
) ();
    logic                         src_done;
    logic [NUM_OQ_WIDTH-1:0]      src_oq;
    logic [PKTS_IN_RAM_WIDTH-1:0] src_num_pkts_in_q;
    logic [WORDS_WIDTH-1:0]       src_num_words_in_q;
    logic [ITER_WIDTH-1:0]        src_curr_iter;
    logic                         dst_done;
    logic [NUM_OQ_WIDTH-1:0]      dst_oq;
    logic [PKTS_IN_RAM_WIDTH-1:0] dst_num_pkts_in_q;
    logic [WORDS_WIDTH-1:0]       dst_num_words_in_q;
    logic                         cfg_wr;
    logic                         cfg_sel;
    logic [NUM_OQ_WIDTH-1:0]      cfg_oq;
    logic [ITER_WIDTH-1:0]        cfg_data;
    logic                         initialize;
    logic [NUM_OQ_WIDTH-1:0]      initialize_oq;
    logic                         pend_ovf_clear;
    logic [NUM_OUTPUT_QUEUES-1:0] empty;
    logic [NUM_OUTPUT_QUEUES-1:0] full;
    logic                         iter_done;
    logic [NUM_OQ_WIDTH-1:0]      iter_done_oq;
    logic                         pend_overflow;

    modport slave (
        input  src_done, src_oq, src_num_pkts_in_q, src_num_words_in_q, src_curr_iter,
        input  dst_done, dst_oq, dst_num_pkts_in_q, dst_num_words_in_q,
        input  cfg_wr, cfg_sel, cfg_oq, cfg_data, initialize, initialize_oq, pend_ovf_clear,
        output empty, full, iter_done, iter_done_oq, pend_overflow
    );

    modport master (
        output src_done, src_oq, src_num_pkts_in_q, src_num_words_in_q, src_curr_iter,
        output dst_done, dst_oq, dst_num_pkts_in_q, dst_num_words_in_q,
        output cfg_wr, cfg_sel, cfg_oq, cfg_data, initialize, initialize_oq, pend_ovf_clear,
        input  empty, full, iter_done, iter_done_oq, pend_overflow
    );
endinterface

// File: rtl/oq_regs_eval_status.sv
// Per-queue empty/full evaluator: one status commit per cycle with priority
// src > dst (pending FIFO first) > cfg (held first) > initialize.
module oq_regs_eval_status #(
    parameter int NUM_OUTPUT_QUEUES   = 8,
    parameter int NUM_OQ_WIDTH        = $clog2(NUM_OUTPUT_QUEUES),
    parameter int PKTS_IN_RAM_WIDTH   = 16,
    parameter int WORDS_WIDTH         = 19,
    parameter int ITER_WIDTH          = 32,
    parameter int PEND_DEPTH          = 4,
    parameter int FULL_THRESH_DEFAULT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    oq_regs_eval_status_if.slave   bus
);
    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       DEPTH_C      = CNT_W'(PEND_DEPTH);
    localparam logic [WORDS_WIDTH-1:0] THRESH_RST_C = WORDS_WIDTH'(FULL_THRESH_DEFAULT);

    typedef struct packed {
        logic [NUM_OQ_WIDTH-1:0]      oq;
        logic [PKTS_IN_RAM_WIDTH-1:0] pkts;
        logic [WORDS_WIDTH-1:0]       words;
    } dst_ev_t;

    logic [NUM_OUTPUT_QUEUES-1:0] pkt_empty_q, pkt_empty_d;
    logic [NUM_OUTPUT_QUEUES-1:0] iter_empty_q, iter_empty_d;
    logic [NUM_OUTPUT_QUEUES-1:0] full_q, full_d;
    logic [ITER_WIDTH-1:0]        max_iter_q [NUM_OUTPUT_QUEUES];
    logic [WORDS_WIDTH-1:0]       thresh_q   [NUM_OUTPUT_QUEUES];
    dst_ev_t                      fifo_q     [PEND_DEPTH];
    logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         hold_vld_q, hold_vld_d;
    logic                         hold_sel_q, hold_sel_d;
    logic [NUM_OQ_WIDTH-1:0]      hold_oq_q, hold_oq_d;
    logic [ITER_WIDTH-1:0]        hold_data_q, hold_data_d;
    logic                         iter_done_q, iter_done_d;
    logic [NUM_OQ_WIDTH-1:0]      iter_done_oq_q, iter_done_oq_d;
    logic                         pend_ovf_q, pend_ovf_d;

    logic                         fifo_empty_s, fifo_full_s;
    logic                         dst_avail_s, cfg_avail_s;
    logic                         sel_src_s, sel_dst_s, sel_cfg_s, sel_init_s;
    logic                         pop_s, push_req_s, push_s, drop_s;
    dst_ev_t                      live_dst_s, dst_ev_s;
    logic                         cfg_sel_s;
    logic [NUM_OQ_WIDTH-1:0]      cfg_oq_s;
    logic [ITER_WIDTH-1:0]        cfg_data_s;
    logic [ITER_WIDTH-1:0]        src_max_s;
    logic                         src_hit_s;
    logic                         max_wr_s, thr_wr_s;
    logic [NUM_OUTPUT_QUEUES-1:0] empty_s;

    // Arbitration: pick the single committing source and derive FIFO push/pop/drop
    always_comb begin
        live_dst_s   = '{oq: bus.dst_oq, pkts: bus.dst_num_pkts_in_q, words: bus.dst_num_words_in_q};
        fifo_empty_s = (cnt_q == '0);
        fifo_full_s  = (cnt_q == DEPTH_C);
        dst_avail_s  = !fifo_empty_s || bus.dst_done;
        cfg_avail_s  = hold_vld_q || bus.cfg_wr;
        sel_src_s    = bus.src_done;
        sel_dst_s    = !bus.src_done && dst_avail_s;
        sel_cfg_s    = !bus.src_done && !dst_avail_s && cfg_avail_s;
        sel_init_s   = !bus.src_done && !dst_avail_s && !cfg_avail_s && bus.initialize;
        pop_s        = sel_dst_s && !fifo_empty_s;
        // A live dst only bypasses the FIFO when it is empty and dst wins
        push_req_s   = bus.dst_done && !(sel_dst_s && fifo_empty_s);
        push_s       = push_req_s && (!fifo_full_s || pop_s);
        drop_s       = push_req_s && fifo_full_s && !pop_s;
        if (fifo_empty_s) begin
            dst_ev_s = live_dst_s;
        end else begin
            dst_ev_s = fifo_q[rd_ptr_q];
        end
        if (hold_vld_q) begin
            cfg_sel_s  = hold_sel_q;
            cfg_oq_s   = hold_oq_q;
            cfg_data_s = hold_data_q;
        end else begin
            cfg_sel_s  = bus.cfg_sel;
            cfg_oq_s   = bus.cfg_oq;
            cfg_data_s = bus.cfg_data;
        end
    end

    // Iteration-limit evaluation for the src update
    always_comb begin
        src_max_s = max_iter_q[bus.src_oq];
        src_hit_s = (src_max_s == '0) || (bus.src_curr_iter >= src_max_s);
    end

    // Commit: next-state of per-queue flags and the iteration-done pulse
    always_comb begin
        pkt_empty_d    = pkt_empty_q;
        iter_empty_d   = iter_empty_q;
        full_d         = full_q;
        max_wr_s       = 1'b0;
        thr_wr_s       = 1'b0;
        iter_done_d    = 1'b0;
        iter_done_oq_d = iter_done_oq_q;
        if (sel_src_s) begin
            pkt_empty_d[bus.src_oq]  = (bus.src_num_pkts_in_q == '0);
            iter_empty_d[bus.src_oq] = src_hit_s;
            full_d[bus.src_oq]       = (bus.src_num_words_in_q >= thresh_q[bus.src_oq]);
            if ((src_max_s != '0) && !iter_empty_q[bus.src_oq] && src_hit_s) begin
                iter_done_d    = 1'b1;
                iter_done_oq_d = bus.src_oq;
            end else begin
                iter_done_d    = 1'b0;
            end
        end else if (sel_dst_s) begin
            pkt_empty_d[dst_ev_s.oq] = (dst_ev_s.pkts == '0);
            full_d[dst_ev_s.oq]      = (dst_ev_s.words >= thresh_q[dst_ev_s.oq]);
        end else if (sel_cfg_s) begin
            if (cfg_sel_s) begin
                thr_wr_s = 1'b1;
            end else begin
                max_wr_s               = 1'b1;
                iter_empty_d[cfg_oq_s] = (cfg_data_s == '0);
            end
        end else if (sel_init_s) begin
            pkt_empty_d[bus.initialize_oq]  = 1'b1;
            iter_empty_d[bus.initialize_oq] = 1'b1;
            full_d[bus.initialize_oq]       = 1'b0;
        end else begin
            iter_done_d = 1'b0;
        end
    end

    // Config hold slot and sticky overflow next-state
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_sel_d  = hold_sel_q;
        hold_oq_d   = hold_oq_q;
        hold_data_d = hold_data_q;
        if (sel_cfg_s && hold_vld_q) begin
            hold_vld_d  = bus.cfg_wr;
            hold_sel_d  = bus.cfg_sel;
            hold_oq_d   = bus.cfg_oq;
            hold_data_d = bus.cfg_data;
        end else if (!hold_vld_q && bus.cfg_wr && !sel_cfg_s) begin
            hold_vld_d  = 1'b1;
            hold_sel_d  = bus.cfg_sel;
            hold_oq_d   = bus.cfg_oq;
            hold_data_d = bus.cfg_data;
        end else begin
            hold_vld_d  = hold_vld_q;
        end
        if (drop_s) begin
            pend_ovf_d = 1'b1;
        end else if (bus.pend_ovf_clear) begin
            pend_ovf_d = 1'b0;
        end else begin
            pend_ovf_d = pend_ovf_q;
        end
    end

    // State registers, pending FIFO and per-queue config storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_empty_q    <= '1;
            iter_empty_q   <= '1;
            full_q         <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            cnt_q          <= '0;
            hold_vld_q     <= 1'b0;
            hold_sel_q     <= 1'b0;
            hold_oq_q      <= '0;
            hold_data_q    <= '0;
            iter_done_q    <= 1'b0;
            iter_done_oq_q <= '0;
            pend_ovf_q     <= 1'b0;
            for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
                max_iter_q[i] <= '0;
                thresh_q[i]   <= THRESH_RST_C;
            end
            for (int i = 0; i < PEND_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pkt_empty_q    <= pkt_empty_d;
            iter_empty_q   <= iter_empty_d;
            full_q         <= full_d;
            hold_vld_q     <= hold_vld_d;
            hold_sel_q     <= hold_sel_d;
            hold_oq_q      <= hold_oq_d;
            hold_data_q    <= hold_data_d;
            iter_done_q    <= iter_done_d;
            iter_done_oq_q <= iter_done_oq_d;
            pend_ovf_q     <= pend_ovf_d;
            if (max_wr_s) begin
                max_iter_q[cfg_oq_s] <= cfg_data_s;
            end
            if (thr_wr_s) begin
                thresh_q[cfg_oq_s] <= cfg_data_s[WORDS_WIDTH-1:0];
            end
            if (push_s) begin
                fifo_q[wr_ptr_q] <= live_dst_s;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Empty view: iteration mode once a nonzero max_iter is programmed
    always_comb begin
        empty_s = '0;
        for (int q = 0; q < NUM_OUTPUT_QUEUES; q++) begin
            if (max_iter_q[q] == '0) begin
                empty_s[q] = pkt_empty_q[q];
            end else begin
                empty_s[q] = iter_empty_q[q];
            end
        end
    end

    assign bus.empty         = empty_s;
    assign bus.full          = full_q;
    assign bus.iter_done     = iter_done_q;
    assign bus.iter_done_oq  = iter_done_oq_q;
    assign bus.pend_overflow = pend_ovf_q;
endmodule
